// File: rtl/score_bcd_if.sv
// Score-to-BCD request/result bundle: the master drives score/load, the converter
// returns busy, the bcd_valid strobe, sat and three digit codes.
interface score_bcd_if;
  logic [15:0] score;
  logic        load;
  logic        busy;
  logic        bcd_valid;
  logic        sat;
  logic [3:0]  digit0;
  logic [3:0]  digit1;
  logic [3:0]  digit2;

  modport master (
    output score, load,
    input  busy, bcd_valid, sat, digit0, digit1, digit2
  );

  modport slave (
    input  score, load,
    output busy, bcd_valid, sat, digit0, digit1, digit2
  );
endinterface

// File: rtl/score_bcd_ctrl.sv
// Saturating binary-to-BCD score converter (double-dabble, 10 shift cycles) with one queued request.
// Define SCORE_LZ_BLANK_EN to blank leading zero hundreds/tens digits with code 4'hF.
module score_bcd_ctrl #(
  parameter int SAT_MAX = 999
) (
  input  logic         clk,
  input  logic         rst_n,
  score_bcd_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_reg;
  logic [9:0]  bin_reg;
  logic [11:0] bcd_reg;
  logic [3:0]  cnt_reg;
  logic        sat_flag_reg;
  logic        pend_reg;
  logic [15:0] pend_score_reg;
  logic        busy_reg;
  logic        valid_reg;
  logic        sat_reg;
  logic [3:0]  digit0_reg;
  logic [3:0]  digit1_reg;
  logic [3:0]  digit2_reg;

  logic [15:0] start_score;
  logic        start_sat;
  logic [9:0]  start_bin;
  logic [11:0] bcd_adj;
  logic [21:0] dd_shift;
  logic [3:0]  hund_out;
  logic [3:0]  tens_out;

  // A fresh load in DONE wins over the queued score.
  assign start_score = (state_reg == DONE && !bus.load) ? pend_score_reg : bus.score;
  assign start_sat   = (start_score > 16'(SAT_MAX));
  assign start_bin   = start_sat ? 10'(SAT_MAX) : start_score[9:0];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ? bcd_reg[gi*4 +: 4] + 4'd3
                                                               : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  assign dd_shift = {bcd_adj, bin_reg} << 1;

`ifdef SCORE_LZ_BLANK_EN
  assign hund_out = (bcd_reg[11:8] == 4'd0) ? 4'hF : bcd_reg[11:8];
  assign tens_out = (bcd_reg[11:8] == 4'd0 && bcd_reg[7:4] == 4'd0) ? 4'hF : bcd_reg[7:4];
`else
  assign hund_out = bcd_reg[11:8];
  assign tens_out = bcd_reg[7:4];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      bin_reg        <= '0;
      bcd_reg        <= '0;
      cnt_reg        <= '0;
      sat_flag_reg   <= 1'b0;
      pend_reg       <= 1'b0;
      pend_score_reg <= '0;
      busy_reg       <= 1'b0;
      valid_reg      <= 1'b0;
      sat_reg        <= 1'b0;
      digit0_reg     <= '0;
      digit1_reg     <= '0;
      digit2_reg     <= '0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.load) begin
            bin_reg      <= start_bin;
            sat_flag_reg <= start_sat;
            bcd_reg      <= '0;
            cnt_reg      <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_reg <= dd_shift[21:10];
          bin_reg <= dd_shift[9:0];
          cnt_reg <= cnt_reg + 4'd1;
          if (cnt_reg == 4'd9) begin
            state_reg <= DONE;
          end
          if (bus.load) begin
            pend_reg       <= 1'b1;
            pend_score_reg <= bus.score;
          end
        end
        DONE: begin
          digit0_reg <= bcd_reg[3:0];
          digit1_reg <= tens_out;
          digit2_reg <= hund_out;
          sat_reg    <= sat_flag_reg;
          valid_reg  <= 1'b1;
          // A load arriving in DONE is still a load-while-busy, so it chains too.
          if (pend_reg || bus.load) begin
            bin_reg      <= start_bin;
            sat_flag_reg <= start_sat;
            bcd_reg      <= '0;
            cnt_reg      <= '0;
            pend_reg     <= 1'b0;
            state_reg    <= SHIFT;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_reg;
  assign bus.bcd_valid = valid_reg;
  assign bus.sat       = sat_reg;
  assign bus.digit0    = digit0_reg;
  assign bus.digit1    = digit1_reg;
  assign bus.digit2    = digit2_reg;

endmodule

// File: tb/tb_score_bcd_ctrl.sv
// Directed bench for score_bcd_ctrl: latency, saturation, queued loads, reset abort,
// blanking (expectations follow SCORE_LZ_BLANK_EN) and back-to-back operation.
module tb_score_bcd_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  score_bcd_if bus ();

  score_bcd_ctrl #(.SAT_MAX(999)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_hund(input logic [3:0] h);
`ifdef SCORE_LZ_BLANK_EN
    return (h == 4'd0) ? 4'hF : h;
`else
    return h;
`endif
  endfunction

  function automatic logic [3:0] exp_tens(input logic [3:0] h, input logic [3:0] t);
`ifdef SCORE_LZ_BLANK_EN
    return (h == 4'd0 && t == 4'd0) ? 4'hF : t;
`else
    return t;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_digits(input string tag, input logic [3:0] h, input logic [3:0] t,
                              input logic [3:0] o);
    check({tag, ".d2"}, 16'(bus.digit2), 16'(exp_hund(h)));
    check({tag, ".d1"}, 16'(bus.digit1), 16'(exp_tens(h, t)));
    check({tag, ".d0"}, 16'(bus.digit0), 16'(o));
  endtask

  // Single conversion from idle: load sampled at edge 0, result expected after edge 11.
  task automatic convert(input string tag, input logic [15:0] s, input logic [3:0] h,
                         input logic [3:0] t, input logic [3:0] o, input logic es);
    int lat;
    int busy_low;
    bus.score = s;
    bus.load  = 1'b1;
    step();
    bus.load  = 1'b0;
    lat       = 0;
    busy_low  = 0;
    check({tag, ".busy0"}, 16'(bus.busy), 16'd1);
    while (bus.bcd_valid !== 1'b1 && lat < 20) begin
      if (bus.busy !== 1'b1) busy_low++;
      step();
      lat++;
    end
    check({tag, ".latency"}, 16'(lat), 16'd11);
    check({tag, ".busy_low"}, 16'(busy_low), 16'd0);
    check_digits(tag, h, t, o);
    check({tag, ".sat"}, 16'(bus.sat), 16'(es));
    check({tag, ".busy_end"}, 16'(bus.busy), 16'd0);
    step();
    check({tag, ".valid_off"}, 16'(bus.bcd_valid), 16'd0);
    check({tag, ".d0_hold"}, 16'(bus.digit0), 16'(o));
    $display("conv %s score=%0d -> %h/%h/%h sat=%0d latency=%0d", tag, s,
             bus.digit2, bus.digit1, bus.digit0, bus.sat, lat);
  endtask

  initial begin
    int vcount;
    int busy_low;

    rst_n     = 1'b0;
    bus.load  = 1'b0;
    bus.score = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", 16'(bus.busy), 16'd0);
    check("rst.valid", 16'(bus.bcd_valid), 16'd0);
    check("rst.sat", 16'(bus.sat), 16'd0);
    check("rst.d0", 16'(bus.digit0), 16'd0);
    check("rst.d1", 16'(bus.digit1), 16'd0);
    check("rst.d2", 16'(bus.digit2), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst.post_valid", 16'(bus.bcd_valid), 16'd0);
    $display("reset: busy=%0d digits=%h/%h/%h", bus.busy, bus.digit2, bus.digit1, bus.digit0);

    convert("basic123", 16'd123, 4'd1, 4'd2, 4'd3, 1'b0);
    convert("sat1500", 16'd1500, 4'd9, 4'd9, 4'd9, 1'b1);
    convert("max999", 16'd999, 4'd9, 4'd9, 4'd9, 1'b0);

    // Loads at edges 3 and 5 while busy: only the latest (678) is queued.
    bus.score = 16'd45;
    bus.load  = 1'b1;
    step();
    bus.load  = 1'b0;
    vcount    = 0;
    for (int e = 1; e <= 30; e++) begin
      bus.load  = (e == 3 || e == 5);
      bus.score = (e == 3) ? 16'd200 : (e == 5) ? 16'd678 : 16'd45;
      step();
      bus.load = 1'b0;
      if (bus.bcd_valid === 1'b1) begin
        vcount++;
        if (vcount == 1) begin
          check("queue.edge1", 16'(e), 16'd11);
          check_digits("queue.first", 4'd0, 4'd4, 4'd5);
        end else begin
          check("queue.edge2", 16'(e), 16'd22);
          check_digits("queue.second", 4'd6, 4'd7, 4'd8);
        end
        $display("queue: valid at edge %0d digits=%h/%h/%h", e,
                 bus.digit2, bus.digit1, bus.digit0);
      end
    end
    check("queue.pulses", 16'(vcount), 16'd2);

    // Reset mid-conversion; a load held during reset must be ignored.
    bus.score = 16'd321;
    bus.load  = 1'b1;
    step();
    bus.load  = 1'b0;
    repeat (5) step();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    bus.score = 16'd5;
    bus.load  = 1'b1;
    #1;
    check("abort.busy", 16'(bus.busy), 16'd0);
    check("abort.valid", 16'(bus.bcd_valid), 16'd0);
    check("abort.d0", 16'(bus.digit0), 16'd0);
    check("abort.d1", 16'(bus.digit1), 16'd0);
    check("abort.d2", 16'(bus.digit2), 16'd0);
    step();
    @(negedge clk);
    bus.load = 1'b0;
    rst_n    = 1'b1;
    vcount   = 0;
    busy_low = 0;
    for (int e = 0; e < 20; e++) begin
      step();
      if (bus.bcd_valid === 1'b1) vcount++;
      if (bus.busy !== 1'b0) busy_low++;
    end
    check("abort.pulses", 16'(vcount), 16'd0);
    check("abort.busy_seen", 16'(busy_low), 16'd0);
    check("abort.d0_after", 16'(bus.digit0), 16'd0);
    $display("abort: pulses=%0d digits=%h/%h/%h", vcount, bus.digit2, bus.digit1, bus.digit0);

    convert("blank7", 16'd7, 4'd0, 4'd0, 4'd7, 1'b0);
    convert("blank40", 16'd40, 4'd0, 4'd4, 4'd0, 1'b0);
    convert("blank0", 16'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    convert("blank305", 16'd305, 4'd3, 4'd0, 4'd5, 1'b0);

    // Load held for edges 0..29: results at 11, 22, 33, 44, busy high through edge 43.
    bus.score = 16'd88;
    bus.load  = 1'b1;
    vcount    = 0;
    busy_low  = 0;
    for (int e = 0; e <= 50; e++) begin
      step();
      if (e == 29) bus.load = 1'b0;
      if (e <= 43 && bus.busy !== 1'b1) busy_low++;
      if (bus.bcd_valid === 1'b1) begin
        vcount++;
        check("b2b.edge", 16'(e), 16'(11 * vcount));
        check_digits("b2b", 4'd0, 4'd8, 4'd8);
        $display("b2b: valid at edge %0d digits=%h/%h/%h", e,
                 bus.digit2, bus.digit1, bus.digit0);
      end
    end
    check("b2b.pulses", 16'(vcount), 16'd4);
    check("b2b.busy_low", 16'(busy_low), 16'd0);
    check("b2b.idle", 16'(bus.busy), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
